// File: rtl/multi_mode_clock_if.sv
// Board-level bundle for multi_mode_clock: debounced buttons in, mode/LED/segment drive out.
interface multi_mode_clock_if;
  logic       btn_mode;
  logic       btn_start;
  logic       btn_pause;
  logic       btn_reset;
  logic [1:0] mode;
  logic       led;
  logic [6:0] seg5;
  logic [6:0] seg4;
  logic [6:0] seg3;
  logic [6:0] seg2;
  logic [6:0] seg1;
  logic [6:0] seg0;

  modport master (
    output btn_mode, btn_start, btn_pause, btn_reset,
    input  mode, led, seg5, seg4, seg3, seg2, seg1, seg0
  );

  modport slave (
    input  btn_mode, btn_start, btn_pause, btn_reset,
    output mode, led, seg5, seg4, seg3, seg2, seg1, seg0
  );
endinterface

// File: rtl/multi_mode_clock.sv
// Time-of-day clock, stopwatch and countdown timer sharing one second tick,
// with a mode-selected 6-digit 7-segment display and a blinking alert LED.
module multi_mode_clock #(
  parameter int unsigned TICKS_PER_SEC  = 50_000_000,
  parameter int unsigned TIMER_PRESET_S = 60,
  parameter int unsigned LED_BLINK_S    = 5
) (
  input logic          clk,
  input logic          rst,
  multi_mode_clock_if.slave bus
);

  localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned LW = $clog2(LED_BLINK_S + 1);
  localparam logic [6:0]  PRE_MM = 7'(TIMER_PRESET_S / 60);
  localparam logic [5:0]  PRE_SS = 6'(TIMER_PRESET_S % 60);

  if (TICKS_PER_SEC < 2) begin : g_bad_tps
    $error("TICKS_PER_SEC must be at least 2");
  end
  if (TIMER_PRESET_S < 1 || TIMER_PRESET_S > 5999) begin : g_bad_preset
    $error("TIMER_PRESET_S must be in 1..5999");
  end
  if (LED_BLINK_S < 1) begin : g_bad_blink
    $error("LED_BLINK_S must be at least 1");
  end

  typedef enum logic [1:0] {
    M_CLOCK = 2'd0,
    M_SW    = 2'd1,
    M_TIMER = 2'd2
  } mode_t;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    btn_now, btn_r, btn_q, edges;
  logic          e_mode, e_start, e_pause, e_reset;

  mode_t         state, state_nxt;
  logic [1:0]    mode_c;
  logic          clk_sel, sw_sel, tm_sel;

  logic [4:0]    c_hh, c_hh_n;
  logic [5:0]    c_mm, c_mm_n, c_ss, c_ss_n;
  logic [6:0]    sw_mm, sw_mm_n;
  logic [5:0]    sw_ss, sw_ss_n;
  logic          sw_run, sw_run_n, sw_trig;
  logic [6:0]    tm_mm, tm_mm_n;
  logic [5:0]    tm_ss, tm_ss_n;
  logic          tm_run, tm_run_n, tm_trig;
  logic [LW-1:0] al_cnt, al_cnt_n;
  logic          led, led_n;

  // Second tick divider and button edge detection (two-stage so the edge lags the press by one cycle)
  assign btn_now = {bus.btn_reset, bus.btn_pause, bus.btn_start, bus.btn_mode};
  assign tick    = (tick_cnt == TW'(TICKS_PER_SEC - 1));
  assign edges   = btn_r & ~btn_q;
  assign e_mode  = edges[0];
  assign e_start = edges[1];
  assign e_pause = edges[2];
  assign e_reset = edges[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      btn_r    <= btn_now;
      btn_q    <= btn_now;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      btn_r    <= btn_now;
      btn_q    <= btn_r;
    end
  end

  // Mode FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= M_CLOCK;
    else     state <= state_nxt;
  end

  // Mode FSM: next state
  always_comb begin
    state_nxt = state;
    if (e_mode) begin
      case (state)
        M_CLOCK: state_nxt = M_SW;
        M_SW:    state_nxt = M_TIMER;
        default: state_nxt = M_CLOCK;
      endcase
    end
  end

  // Mode FSM: outputs
  always_comb begin
    mode_c  = 2'd0;
    clk_sel = 1'b0;
    sw_sel  = 1'b0;
    tm_sel  = 1'b0;
    case (state)
      M_SW:    begin mode_c = 2'd1; sw_sel = 1'b1; end
      M_TIMER: begin mode_c = 2'd2; tm_sel = 1'b1; end
      default: begin mode_c = 2'd0; clk_sel = 1'b1; end
    endcase
  end

  // Time of day: tick first, then manual HH/MM bumps on the ticked value
  always_comb begin
    c_hh_n = c_hh;
    c_mm_n = c_mm;
    c_ss_n = c_ss;
    if (clk_sel && e_reset) begin
      c_ss_n = '0;
    end else if (tick) begin
      if (c_ss == 6'd59) begin
        c_ss_n = '0;
        if (c_mm == 6'd59) begin
          c_mm_n = '0;
          c_hh_n = (c_hh == 5'd23) ? '0 : c_hh + 5'd1;
        end else begin
          c_mm_n = c_mm + 6'd1;
        end
      end else begin
        c_ss_n = c_ss + 6'd1;
      end
    end
    if (clk_sel && e_start) c_hh_n = (c_hh_n == 5'd23) ? '0 : c_hh_n + 5'd1;
    if (clk_sel && e_pause) c_mm_n = (c_mm_n == 6'd59) ? '0 : c_mm_n + 6'd1;
  end

  // Stopwatch: reset > pause > start > tick; 99:59 wraps and raises the alert
  always_comb begin
    sw_mm_n  = sw_mm;
    sw_ss_n  = sw_ss;
    sw_run_n = sw_run;
    sw_trig  = 1'b0;
    if (sw_sel && e_reset) begin
      sw_mm_n  = '0;
      sw_ss_n  = '0;
      sw_run_n = 1'b0;
    end else if (sw_sel && e_pause) begin
      sw_run_n = 1'b0;
    end else if (sw_sel && e_start) begin
      sw_run_n = 1'b1;
    end else if (tick && sw_run) begin
      if (sw_ss == 6'd59) begin
        sw_ss_n = '0;
        if (sw_mm == 7'd99) begin
          sw_mm_n = '0;
          sw_trig = 1'b1;
        end else begin
          sw_mm_n = sw_mm + 7'd1;
        end
      end else begin
        sw_ss_n = sw_ss + 6'd1;
      end
    end
  end

  // Countdown timer: same priority; expiry stops it and raises the alert
  always_comb begin
    tm_mm_n  = tm_mm;
    tm_ss_n  = tm_ss;
    tm_run_n = tm_run;
    tm_trig  = 1'b0;
    if (tm_sel && e_reset) begin
      tm_mm_n  = PRE_MM;
      tm_ss_n  = PRE_SS;
      tm_run_n = 1'b0;
    end else if (tm_sel && e_pause) begin
      tm_run_n = 1'b0;
    end else if (tm_sel && e_start) begin
      if (tm_mm != '0 || tm_ss != '0) tm_run_n = 1'b1;
    end else if (tick && tm_run) begin
      if (tm_mm == '0 && tm_ss == 6'd1) begin
        tm_ss_n  = '0;
        tm_run_n = 1'b0;
        tm_trig  = 1'b1;
      end else if (tm_ss == '0) begin
        tm_ss_n = 6'd59;
        tm_mm_n = tm_mm - 7'd1;
      end else begin
        tm_ss_n = tm_ss - 6'd1;
      end
    end
  end

  // Alert: a trigger beats a same-cycle cancel from any function button
  always_comb begin
    al_cnt_n = al_cnt;
    led_n    = led;
    if (sw_trig || tm_trig) begin
      al_cnt_n = LW'(LED_BLINK_S);
      led_n    = 1'b1;
    end else if (e_start || e_pause || e_reset) begin
      al_cnt_n = '0;
      led_n    = 1'b0;
    end else if (tick && al_cnt != '0) begin
      al_cnt_n = al_cnt - LW'(1);
      led_n    = (al_cnt == LW'(1)) ? 1'b0 : ~led;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_hh   <= '0;
      c_mm   <= '0;
      c_ss   <= '0;
      sw_mm  <= '0;
      sw_ss  <= '0;
      sw_run <= 1'b0;
      tm_mm  <= PRE_MM;
      tm_ss  <= PRE_SS;
      tm_run <= 1'b0;
      al_cnt <= '0;
      led    <= 1'b0;
    end else begin
      c_hh   <= c_hh_n;
      c_mm   <= c_mm_n;
      c_ss   <= c_ss_n;
      sw_mm  <= sw_mm_n;
      sw_ss  <= sw_ss_n;
      sw_run <= sw_run_n;
      tm_mm  <= tm_mm_n;
      tm_ss  <= tm_ss_n;
      tm_run <= tm_run_n;
      al_cnt <= al_cnt_n;
      led    <= led_n;
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h00;
    endcase
  endfunction

  function automatic logic [13:0] two_digits(input logic [6:0] v);
    two_digits = {glyph(4'(v / 7'd10)), glyph(4'(v % 7'd10))};
  endfunction

  // Display decode from registered state
  logic [41:0] segs_c;
  always_comb begin
    segs_c = '0;
    case (state)
      M_SW:    segs_c = {14'h0, two_digits(sw_mm), two_digits(7'(sw_ss))};
      M_TIMER: segs_c = {14'h0, two_digits(tm_mm), two_digits(7'(tm_ss))};
      default: segs_c = {two_digits(7'(c_hh)), two_digits(7'(c_mm)), two_digits(7'(c_ss))};
    endcase
  end

  assign bus.mode = mode_c;
  assign bus.led  = led;
  assign bus.seg5 = segs_c[41:35];
  assign bus.seg4 = segs_c[34:28];
  assign bus.seg3 = segs_c[27:21];
  assign bus.seg2 = segs_c[20:14];
  assign bus.seg1 = segs_c[13:7];
  assign bus.seg0 = segs_c[6:0];

endmodule

// File: tb/tb_multi_mode_clock.sv
// Directed bench for multi_mode_clock with a 4-cycle second, 5 s timer preset and 1 s alert.
module tb_multi_mode_clock;

  localparam int unsigned TPS   = 4;
  localparam int unsigned PRE   = 5;
  localparam int unsigned BLINK = 1;

  localparam logic [3:0] B_MODE  = 4'b0001;
  localparam logic [3:0] B_START = 4'b0010;
  localparam logic [3:0] B_PAUSE = 4'b0100;
  localparam logic [3:0] B_RESET = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  multi_mode_clock_if bus();

  multi_mode_clock #(
    .TICKS_PER_SEC (TPS),
    .TIMER_PRESET_S(PRE),
    .LED_BLINK_S   (BLINK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Cycles since reset released; the DUT tick counter equals cyc % TPS
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [41:0] disp_clock(input int hh, input int mm, input int ss);
    return {glyph(hh / 10), glyph(hh % 10), glyph(mm / 10), glyph(mm % 10),
            glyph(ss / 10), glyph(ss % 10)};
  endfunction

  function automatic logic [41:0] disp_mmss(input int mm, input int ss);
    return {14'h0, glyph(mm / 10), glyph(mm % 10), glyph(ss / 10), glyph(ss % 10)};
  endfunction

  function automatic logic [41:0] seg_all();
    return {bus.seg5, bus.seg4, bus.seg3, bus.seg2, bus.seg1, bus.seg0};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic set_btns(input logic [3:0] m);
    {bus.btn_reset, bus.btn_pause, bus.btn_start, bus.btn_mode} = m;
  endtask

  // One-cycle press; returns two cycles later, when the edge's effect is visible
  task automatic press(input logic [3:0] m);
    set_btns(m);
    step(1);
    set_btns(4'b0000);
    step(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    set_btns(4'b0000);

    // Reset state and tick rate
    do_reset();
    check("rst_mode", 64'(bus.mode), 64'(0));
    check("rst_led",  64'(bus.led),  64'(0));
    check("rst_seg",  64'(seg_all()), 64'(disp_clock(0, 0, 0)));
    run_to(3);
    check("pre_first_tick", 64'(seg_all()), 64'(disp_clock(0, 0, 0)));
    run_to(4);
    check("first_tick", 64'(seg_all()), 64'(disp_clock(0, 0, 1)));
    run_to(4 * 3661);
    check("clock_3661s", 64'(seg_all()), 64'(disp_clock(1, 1, 1)));

    // Clock setting: 23:59:xx via buttons, then HH bump in the wrapping tick cycle
    do_reset();
    for (int i = 0; i < 23; i++) press(B_START);
    for (int i = 0; i < 59; i++) press(B_PAUSE);
    run_to(238);
    check("clock_235959", 64'(seg_all()), 64'(disp_clock(23, 59, 59)));
    press(B_START);
    check("clock_wrap_hh", 64'(seg_all()), 64'(disp_clock(1, 0, 0)));
    for (int i = 0; i < 59; i++) press(B_PAUSE);
    check("clock_mm59", 64'(seg_all()), 64'(disp_clock(1, 59, 29)));
    press(B_PAUSE);
    check("clock_mm_nocarry", 64'(seg_all()), 64'(disp_clock(1, 0, 30)));
    press(B_RESET);
    check("clock_ss_clear", 64'(seg_all()), 64'(disp_clock(1, 0, 0)));

    // Stopwatch full-range run and wrap alert
    do_reset();
    press(B_MODE);
    check("sw_mode", 64'(bus.mode), 64'(1));
    check("sw_blank", 64'(seg_all()), 64'(disp_mmss(0, 0)));
    press(B_START);
    run_to(24000);
    check("sw_9959", 64'(seg_all()), 64'(disp_mmss(99, 59)));
    check("sw_led_before", 64'(bus.led), 64'(0));
    run_to(24004);
    check("sw_wrap", 64'(seg_all()), 64'(disp_mmss(0, 0)));
    check("sw_wrap_led", 64'(bus.led), 64'(1));
    run_to(24008);
    check("sw_still_run", 64'(seg_all()), 64'(disp_mmss(0, 1)));
    check("sw_led_done", 64'(bus.led), 64'(0));
    run_to(24012);
    check("sw_0002", 64'(seg_all()), 64'(disp_mmss(0, 2)));

    // Priority: reset+start clears and stops; pause+start stops even in a tick cycle
    press(B_RESET | B_START);
    check("sw_rst_start", 64'(seg_all()), 64'(disp_mmss(0, 0)));
    run_to(24022);
    check("sw_rst_stopped", 64'(seg_all()), 64'(disp_mmss(0, 0)));
    run_to(24024);
    press(B_START);
    run_to(24034);
    check("sw_restart", 64'(seg_all()), 64'(disp_mmss(0, 2)));
    press(B_PAUSE | B_START);
    run_to(24044);
    check("sw_pause_start", 64'(seg_all()), 64'(disp_mmss(0, 2)));

    // Timer countdown, expiry alert, cancel, start at zero, reload
    run_to(24048);
    press(B_MODE);
    check("tm_mode", 64'(bus.mode), 64'(2));
    check("tm_preset", 64'(seg_all()), 64'(disp_mmss(0, 5)));
    run_to(24052);
    press(B_START);
    run_to(24068);
    check("tm_0001", 64'(seg_all()), 64'(disp_mmss(0, 1)));
    check("tm_led_pre", 64'(bus.led), 64'(0));
    run_to(24072);
    check("tm_expire", 64'(seg_all()), 64'(disp_mmss(0, 0)));
    check("tm_led", 64'(bus.led), 64'(1));
    press(B_PAUSE);
    check("alert_cancel", 64'(bus.led), 64'(0));
    run_to(24082);
    check("tm_stopped", 64'(seg_all()), 64'(disp_mmss(0, 0)));
    press(B_START);
    run_to(24092);
    check("tm_start_zero", 64'(seg_all()), 64'(disp_mmss(0, 0)));
    press(B_RESET);
    check("tm_reload", 64'(seg_all()), 64'(disp_mmss(0, 5)));
    run_to(24100);
    check("tm_reload_stop", 64'(seg_all()), 64'(disp_mmss(0, 5)));

    // Back to clock mode; clock ran in the background untouched
    press(B_MODE);
    check("mode_wrap", 64'(bus.mode), 64'(0));
    check("clock_bg", 64'(seg_all()),
          64'(disp_clock((cyc / 4) / 3600 % 24, (cyc / 4) / 60 % 60, (cyc / 4) % 60)));

    // Mid-count reset with btn_mode held through it: no edge afterwards
    set_btns(B_MODE);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_mode", 64'(bus.mode), 64'(0));
    check("mid_rst_led",  64'(bus.led),  64'(0));
    check("mid_rst_seg",  64'(seg_all()), 64'(disp_clock(0, 0, 0)));
    step(3);
    set_btns(4'b0000);
    step(2);
    check("held_btn_no_edge", 64'(bus.mode), 64'(0));
    press(B_MODE);
    check("mid_rst_sw", 64'(seg_all()), 64'(disp_mmss(0, 0)));
    press(B_MODE);
    check("mid_rst_tm", 64'(seg_all()), 64'(disp_mmss(0, 5)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
